timer_counter: RTL

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter_if.sv | 13 +
 rtl/timer_counter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/timer_counter_if.sv
// CPU bridge bus for the timer: write strobe, byte enables, address,
// write data, combinational read data and the interrupt line.
interface timer_counter_if;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output we, byteen, addr, wdata, input rdata, irq);
  modport slave  (input we, byteen, addr, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// Programmable down-counting timer with one-shot / auto-reload modes,
// byte-writable CTRL/PRESET registers and a maskable interrupt.

// One byte lane of a byte-enabled register write.
module timer_counter_lane #(
  parameter int VEC_W = 8
) (
  input  logic             be,
  input  logic [VEC_W-1:0] old_byte,
  input  logic [VEC_W-1:0] new_byte,
  output logic [VEC_W-1:0] merged
);
  assign merged = be ? new_byte : old_byte;
endmodule

module timer_counter (
  input logic            clk,
  input logic            reset,
  timer_counter_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  // Only the low nibble of CTRL is stored; upper bits read back as zero.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  state_t                              state;
  ctrl_t                               ctrl;
  logic [NUM_LANES-1:0][VEC_W-1:0]     preset;
  logic [NUM_LANES-1:0][VEC_W-1:0]     preset_nxt;
  logic [NUM_LANES-1:0][VEC_W-1:0]     wdata_lanes;
  logic [31:0]                         count;
  logic                                flag;

  logic [1:0] sel;
  logic       wr_any;
  logic       wr_ctrl;
  logic       wr_ctrl_b0;
  logic       wr_preset;

  // Base decode happens outside; only addr[3:2] selects a register here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:4], bus.addr[1:0]};

  assign sel         = bus.addr[3:2];
  assign wr_any      = bus.we && (bus.byteen != 4'b0000);
  assign wr_ctrl     = wr_any && (sel == A_CTRL);
  assign wr_preset   = wr_any && (sel == A_PRESET);
  // All stored CTRL fields live in byte 0.
  assign wr_ctrl_b0  = wr_ctrl && bus.byteen[0];
  assign wdata_lanes = bus.wdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    timer_counter_lane #(.VEC_W(VEC_W)) u_lane (
      .be       (wr_preset & bus.byteen[i]),
      .old_byte (preset[i]),
      .new_byte (wdata_lanes[i]),
      .merged   (preset_nxt[i])
    );
  end

  // PRESET register: byte-merged CPU writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) preset <= '0;
    else       preset <= preset_nxt;
  end

  // Counter FSM plus CTRL/flag updates; a same-edge CPU write to CTRL
  // overrides the FSM's EN clear, and any CTRL/PRESET write clears flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ctrl  <= '0;
      count <= '0;
      flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ctrl.en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl.en) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            // Covers PRESET of 0 and 1: expire without wrapping.
            count <= '0;
            flag  <= 1'b1;
            state <= INT;
          end
        end
        INT: begin
          if (ctrl.mode == 2'd1) begin
            flag  <= 1'b0;
            state <= LOAD;
          end else begin
            ctrl.en <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (wr_ctrl_b0)           ctrl <= ctrl_t'(bus.wdata[3:0]);
      if (wr_ctrl || wr_preset) flag <= 1'b0;
    end
  end

  // Read mux, purely from addr and current register state.
  always_comb begin
    bus.rdata = '0;
    case (sel)
      A_CTRL:   bus.rdata = {28'd0, ctrl};
      A_PRESET: bus.rdata = preset;
      A_COUNT:  bus.rdata = count;
      default:  bus.rdata = '0;
    endcase
  end

  assign bus.irq = ctrl.im & flag;
endmodule
